// File: rtl/int_ctrl_pkg.sv
// Shared constants and types for the interrupt controller: register map,
// default sizing and well-known source numbers.
package int_ctrl_pkg;
  localparam int N_SRC_DEF = 6;
  localparam int ID_W_DEF  = 4;

  localparam logic [2:0] OFF_MASK  = 3'd0;
  localparam logic [2:0] OFF_MODE  = 3'd1;
  localparam logic [2:0] OFF_PEND  = 3'd2;
  localparam logic [2:0] OFF_INSVC = 3'd3;
  localparam logic [2:0] OFF_EOI   = 3'd4;
  localparam logic [2:0] OFF_CUR   = 3'd5;

  localparam int SRC_TIMER0 = 0;
  localparam int SRC_TIMER1 = 1;
  localparam int SRC_EXT    = 2;

  typedef struct packed {
    logic mask;
    logic mode;
    logic pend;
    logic eoi;
  } reg_wr_t;
endpackage

// File: rtl/int_prio_enc.sv
// Lowest-index-first priority encoder; index 0 is the highest priority.
module int_prio_enc #(
  parameter int N = 6,
  parameter int W = 4
) (
  input  logic [N-1:0] vec,
  output logic         found,
  output logic [W-1:0] idx
);
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) begin
        found = 1'b1;
        idx   = W'(i);
      end
    end
  end
endmodule

// File: rtl/int_ctrl.sv
// Programmable interrupt controller: latches, masks and prioritises sources,
// tracks in-service nesting and presents one registered request/ID to the CPU.
module int_ctrl
  import int_ctrl_pkg::*;
#(
  parameter int N_SRC = N_SRC_DEF,
  parameter int ID_W  = ID_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_SRC-1:0] irq_in,
  input  logic [2:0]       Addr,
  input  logic             WE,
  input  logic [31:0]      Din,
  output logic [31:0]      Dout,
  input  logic             int_ack,
  output logic             int_req,
  output logic [ID_W-1:0]  int_id
);
  logic [N_SRC-1:0] mask, mode, pend, insvc, irq_q;
  logic [N_SRC-1:0] mode_n, pend_n, insvc_n;
  logic [N_SRC-1:0] elig, rise, w1c, ack_bit, eoi_bit;
  logic             win_found, top_found, ack_ok, req_n;
  logic [ID_W-1:0]  win, top;
  reg_wr_t          wr;

  assign wr.mask = WE && (Addr == OFF_MASK);
  assign wr.mode = WE && (Addr == OFF_MODE);
  assign wr.pend = WE && (Addr == OFF_PEND);
  assign wr.eoi  = WE && (Addr == OFF_EOI);

  assign elig   = pend & mask;
  assign ack_ok = int_ack && int_req;
  assign rise   = irq_in & ~irq_q;

  int_prio_enc #(.N(N_SRC), .W(ID_W)) u_win (.vec(elig),  .found(win_found), .idx(win));
  int_prio_enc #(.N(N_SRC), .W(ID_W)) u_top (.vec(insvc), .found(top_found), .idx(top));

  always_comb begin
    mode_n  = wr.mode ? Din[N_SRC-1:0] : mode;
    w1c     = wr.pend ? Din[N_SRC-1:0] : '0;
    ack_bit = '0;
    eoi_bit = '0;
    for (int i = 0; i < N_SRC; i++) begin
      ack_bit[i] = ack_ok && (int_id == ID_W'(i));
      eoi_bit[i] = wr.eoi && top_found && (top == ID_W'(i));
    end
    // Edge bits: clears lose to a fresh rising edge. A level->edge switch
    // starts from a clean PEND; level bits simply follow the line.
    pend_n  = (mode_n & mode & ((pend & ~((w1c | ack_bit) & mode)) | rise))
            | (~mode_n & irq_in);
    insvc_n = (insvc & ~eoi_bit) | ack_bit;
    // Hold off during the ack cycle so the just-acked source is not
    // re-requested before INSVC reflects it.
    req_n   = win_found && (!top_found || (win < top)) && !ack_ok;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mask    <= '0;
      mode    <= '0;
      pend    <= '0;
      insvc   <= '0;
      irq_q   <= '0;
      int_req <= 1'b0;
      int_id  <= '0;
    end else begin
      if (wr.mask) mask <= Din[N_SRC-1:0];
      mode    <= mode_n;
      pend    <= pend_n;
      insvc   <= insvc_n;
      irq_q   <= irq_in;
      int_req <= req_n;
      int_id  <= req_n ? win : '0;
    end
  end

  always_comb begin
    Dout = '0;
    case (Addr)
      OFF_MASK:  Dout[N_SRC-1:0] = mask;
      OFF_MODE:  Dout[N_SRC-1:0] = mode;
      OFF_PEND:  Dout[N_SRC-1:0] = pend;
      OFF_INSVC: Dout[N_SRC-1:0] = insvc;
      OFF_CUR: begin
        Dout[31]       = int_req;
        Dout[ID_W-1:0] = int_id;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_int_ctrl.sv
// Bench for int_ctrl: directed walk through the main scenarios with literal
// expectations, then randomized traffic against a behavioural model.
module tb_int_ctrl;
  localparam int N  = 6;
  localparam int IW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [N-1:0]  irq_in = '0;
  logic [2:0]    Addr = '0;
  logic          WE = 1'b0;
  logic [31:0]   Din = '0;
  logic          int_ack = 1'b0;
  logic [31:0]   Dout;
  logic          int_req;
  logic [IW-1:0] int_id;

  int_ctrl #(.N_SRC(N), .ID_W(IW)) dut (
    .clk(clk), .reset(reset), .irq_in(irq_in), .Addr(Addr), .WE(WE),
    .Din(Din), .Dout(Dout), .int_ack(int_ack), .int_req(int_req), .int_id(int_id)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit started = 1'b0;

  bit [N-1:0] m_mask, m_mode, m_pend, m_insvc, m_irqq;
  bit         m_req;
  int         m_id;

  function automatic int lowest(input bit [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return N;
  endfunction

  function automatic logic [31:0] model_rd(input logic [2:0] a);
    logic [31:0] r;
    r = '0;
    case (a)
      3'd0: r[N-1:0] = m_mask;
      3'd1: r[N-1:0] = m_mode;
      3'd2: r[N-1:0] = m_pend;
      3'd3: r[N-1:0] = m_insvc;
      3'd5: r = {m_req, 31'(m_id)};
      default: r = '0;
    endcase
    return r;
  endfunction

  // One clock edge of the controller, derived from the register-level rules.
  task automatic model_step();
    int win, top;
    bit acc;
    bit [N-1:0] nmask, nmode, npend, nins;
    if (reset) begin
      m_mask = '0; m_mode = '0; m_pend = '0; m_insvc = '0; m_irqq = '0;
      m_req = 1'b0; m_id = 0;
      return;
    end
    win   = lowest(m_pend & m_mask);
    top   = lowest(m_insvc);
    acc   = int_ack && m_req;
    nmask = (WE && Addr == 3'd0) ? Din[N-1:0] : m_mask;
    nmode = (WE && Addr == 3'd1) ? Din[N-1:0] : m_mode;
    nins  = m_insvc;
    if (WE && Addr == 3'd4 && top < N) nins[top] = 1'b0;
    if (acc) nins[m_id] = 1'b1;
    for (int i = 0; i < N; i++) begin
      if (!nmode[i])      npend[i] = irq_in[i];
      else if (!m_mode[i]) npend[i] = 1'b0;
      else begin
        npend[i] = m_pend[i];
        if (WE && Addr == 3'd2 && Din[i]) npend[i] = 1'b0;
        if (acc && m_id == i) npend[i] = 1'b0;
        if (irq_in[i] && !m_irqq[i]) npend[i] = 1'b1;
      end
    end
    m_req   = (win < N) && (top == N || win < top) && !acc;
    m_id    = m_req ? win : 0;
    m_mask  = nmask;
    m_mode  = nmode;
    m_pend  = npend;
    m_insvc = nins;
    m_irqq  = irq_in;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic cyc(input bit r, input logic [N-1:0] irq, input logic [2:0] a,
                     input bit we, input logic [31:0] d, input bit ack);
    @(negedge clk);
    #2;
    reset = r; irq_in = irq; Addr = a; WE = we; Din = d; int_ack = ack;
    @(posedge clk);
    model_step();
    #1;
  endtask

  always @(negedge clk) begin
    if (started) begin
      chk("int_req", 32'(int_req), 32'(m_req));
      chk("int_id", 32'(int_id), 32'(m_id));
      chk("dout", Dout, model_rd(Addr));
    end
  end

  initial begin
    cyc(1, '0, 3'd0, 0, 0, 0);
    started = 1'b1;
    cyc(1, '0, 3'd5, 0, 0, 0);
    chk("rst_cur", Dout, 32'h0);
    cyc(0, '0, 3'd0, 1, 32'h3F, 0);
    cyc(0, '0, 3'd1, 1, 32'h3F, 0);

    cyc(0, 6'h04, 3'd2, 0, 0, 0);
    chk("e1_pend", Dout, 32'h04);
    chk("e1_req", 32'(int_req), 32'h0);
    cyc(0, 6'h00, 3'd5, 0, 0, 0);
    chk("e2_cur", Dout, 32'h8000_0002);
    cyc(0, 6'h00, 3'd3, 0, 0, 1);
    chk("ack_insvc", Dout, 32'h04);
    cyc(0, 6'h08, 3'd2, 0, 0, 0);
    chk("ack_pend", Dout, 32'h08);
    cyc(0, 6'h08, 3'd5, 0, 0, 0);
    chk("lower_blocked", Dout, 32'h0);
    cyc(0, 6'h08, 3'd4, 1, 32'hFFFF_FFFF, 0);
    chk("eoi_rd0", Dout, 32'h0);
    cyc(0, 6'h08, 3'd3, 0, 0, 0);
    chk("eoi_insvc", Dout, 32'h0);
    chk("eoi_req", 32'({int_req, int_id}), 32'h13);
    cyc(0, 6'h00, 3'd0, 0, 0, 1);
    cyc(0, 6'h00, 3'd4, 1, 0, 0);

    // nesting: source 0 preempts source 2
    cyc(0, 6'h04, 3'd0, 0, 0, 0);
    cyc(0, 6'h00, 3'd0, 0, 0, 0);
    cyc(0, 6'h00, 3'd0, 0, 0, 1);
    cyc(0, 6'h01, 3'd0, 0, 0, 0);
    cyc(0, 6'h00, 3'd5, 0, 0, 0);
    chk("nest_cur", Dout, 32'h8000_0000);
    cyc(0, 6'h00, 3'd3, 0, 0, 1);
    chk("nest_insvc", Dout, 32'h05);
    cyc(0, 6'h00, 3'd4, 1, 0, 0);
    cyc(0, 6'h00, 3'd3, 0, 0, 0);
    chk("eoi1_insvc", Dout, 32'h04);
    cyc(0, 6'h00, 3'd4, 1, 0, 0);
    cyc(0, 6'h00, 3'd3, 0, 0, 0);
    chk("eoi2_insvc", Dout, 32'h0);

    // new edge on source 1 beats a same-cycle W1C
    cyc(0, 6'h02, 3'd2, 1, 32'h02, 0);
    chk("w1c_vs_edge", Dout, 32'h02);

    // level mode on source 4
    cyc(0, 6'h00, 3'd2, 1, 32'h3F, 0);
    cyc(0, 6'h10, 3'd1, 1, 32'h00, 0);
    cyc(0, 6'h10, 3'd2, 0, 0, 0);
    chk("lvl_pend", Dout, 32'h10);
    cyc(0, 6'h10, 3'd5, 0, 0, 0);
    chk("lvl_req", Dout, 32'h8000_0004);
    cyc(0, 6'h00, 3'd2, 0, 0, 0);
    chk("lvl_drop", Dout, 32'h0);

    cyc(1, 6'h00, 3'd5, 0, 0, 1);
    chk("rst_mid", Dout, 32'h0);

    for (int k = 0; k < 3000; k++) begin
      logic [N-1:0] nirq;
      logic [2:0]   a;
      bit           r, we, ack;
      nirq = irq_in ^ N'($urandom & $urandom & $urandom);
      a    = 3'($urandom_range(0, 7));
      we   = ($urandom_range(0, 3) == 0);
      ack  = m_req ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 15) == 0);
      r    = ($urandom_range(0, 299) == 0);
      cyc(r, nirq, a, we, $urandom, ack);
    end

    @(negedge clk);
    #2;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
